// File: rtl/id_ex_debug_reader_pkg.sv
// Shared constants, types and the frame byte selector for the ID/EX debug reader.
package id_ex_debug_reader_pkg;

    localparam int PC_BITS           = 32;
    localparam int PROC_BITS         = 32;
    localparam int OPCODE_BITS       = 6;
    localparam int REG_ADDRS_BITS    = 5;
    localparam int DBG_CTRL_BITS     = 15;
    localparam int DBG_IDEX_BUS_BITS = 196;
    localparam int DBG_FRAME_BYTES   = 29;
    localparam int DBG_FRAME_BITS    = 8 * DBG_FRAME_BYTES;
    localparam int DBG_IDX_BITS      = 5;

    localparam logic [7:0]              DBG_HEADER   = 8'hA5;
    localparam logic [DBG_IDX_BITS-1:0] DBG_LAST_IDX = 5'(DBG_FRAME_BYTES - 1);

    typedef enum logic [1:0] {
        DBG_IDLE = 2'd0,
        DBG_SEND = 2'd1,
        DBG_DONE = 2'd2
    } dbg_state_e;

    // Field order matches the latch bus, MSB first.
    typedef struct packed {
        logic [PC_BITS-1:0]        pc_next;
        logic [OPCODE_BITS-1:0]    opcode;
        logic [PROC_BITS-1:0]      read_data_1;
        logic [PROC_BITS-1:0]      read_data_2;
        logic [PROC_BITS-1:0]      imm_ext;
        logic [PC_BITS-1:0]        jump_address;
        logic [REG_ADDRS_BITS-1:0] rs;
        logic [REG_ADDRS_BITS-1:0] rt;
        logic [REG_ADDRS_BITS-1:0] rd;
        logic [DBG_CTRL_BITS-1:0]  ctrl;
    } id_ex_bus_t;

    // Byte idx of the frame: header, then seven 32-bit words, MSB byte first.
    function automatic logic [7:0] dbg_frame_byte(input id_ex_bus_t snap,
                                                  input logic [DBG_IDX_BITS-1:0] idx);
        logic [DBG_FRAME_BITS-1:0] frame;
        logic [DBG_FRAME_BITS-1:0] shifted;
        int unsigned               shift;
        frame = {DBG_HEADER,
                 snap.pc_next,
                 snap.read_data_1,
                 snap.read_data_2,
                 snap.imm_ext,
                 snap.jump_address,
                 snap.opcode, snap.rs, snap.rt, snap.rd, 11'b0,
                 17'b0, snap.ctrl};
        if (idx > DBG_LAST_IDX) begin
            return 8'h00;
        end
        shift   = 8 * (32'(DBG_LAST_IDX) - 32'(idx));
        shifted = frame >> shift;
        return shifted[7:0];
    endfunction

endpackage

// File: rtl/id_ex_debug_reader.sv
// Snapshots the ID/EX latch on request and streams it as a 29-byte frame
// over a valid/ready byte interface. Purely observational: no path back
// into the pipeline.
module id_ex_debug_reader
    import id_ex_debug_reader_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_snap_req,
    input  logic [DBG_IDEX_BUS_BITS-1:0] i_id_ex_bus,
    input  logic                         i_tx_ready,
    output logic [7:0]                   o_tx_data,
    output logic                         o_tx_valid,
    output logic                         o_busy,
    output logic                         o_done
);

    dbg_state_e              state_q, state_d;
    logic [DBG_IDX_BITS-1:0] idx_q, idx_d;
    id_ex_bus_t              snap_q, snap_d;

    // State, byte index and snapshot registers; active-low synchronous reset aborts any frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DBG_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
        end
    end

    // Next state: capture on request in IDLE, advance the index on each accepted byte.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        case (state_q)
            DBG_IDLE: begin
                if (i_snap_req) begin
                    snap_d  = id_ex_bus_t'(i_id_ex_bus);
                    idx_d   = '0;
                    state_d = DBG_SEND;
                end
            end
            DBG_SEND: begin
                // o_tx_valid is always high here, so ready alone completes a handshake.
                if (i_tx_ready) begin
                    if (idx_q == DBG_LAST_IDX) begin
                        state_d = DBG_DONE;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            DBG_DONE: begin
                state_d = DBG_IDLE;
            end
            default: begin
                state_d = DBG_IDLE;
            end
        endcase
    end

    // Outputs are decoded from registered state only, so data holds steady under back-pressure.
    always_comb begin
        o_tx_data  = 8'h00;
        o_tx_valid = 1'b0;
        o_busy     = 1'b0;
        o_done     = 1'b0;
        case (state_q)
            DBG_SEND: begin
                o_tx_valid = 1'b1;
                o_busy     = 1'b1;
                o_tx_data  = dbg_frame_byte(snap_q, idx_q);
            end
            DBG_DONE: begin
                o_done = 1'b1;
                o_busy = 1'b1;
            end
            default: begin
                o_tx_data = 8'h00;
            end
        endcase
    end

endmodule

// File: tb/tb_id_ex_debug_reader.sv
// Scoreboard bench for id_ex_debug_reader: requests push the expected frame,
// a negedge monitor pops and compares each accepted byte.
module tb_id_ex_debug_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         i_snap_req;
    logic [195:0] i_id_ex_bus;
    logic         i_tx_ready;
    logic [7:0]   o_tx_data;
    logic         o_tx_valid;
    logic         o_busy;
    logic         o_done;

    always #5 clk = ~clk;

    id_ex_debug_reader dut (
        .clk         (clk),
        .rst         (rst),
        .i_snap_req  (i_snap_req),
        .i_id_ex_bus (i_id_ex_bus),
        .i_tx_ready  (i_tx_ready),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        int unsigned pc, rd1, rd2, imm, jmp;
        int unsigned op, rs, rt, rd;
        int unsigned regdst, regwrite, memread, memwrite, memtoreg;
        int unsigned aluop, alusrc, shamt, lsop, br;
    } fields_t;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_done = 0;
    int         got_done = 0;
    int         popped_in_frame = 0;
    int         ready_mode = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic fields_t rand_fields();
        fields_t f;
        f.pc = $urandom; f.rd1 = $urandom; f.rd2 = $urandom;
        f.imm = $urandom; f.jmp = $urandom;
        f.op = $urandom_range(0, 63);
        f.rs = $urandom_range(0, 31); f.rt = $urandom_range(0, 31); f.rd = $urandom_range(0, 31);
        f.regdst = $urandom_range(0, 1); f.regwrite = $urandom_range(0, 1);
        f.memread = $urandom_range(0, 1); f.memwrite = $urandom_range(0, 1);
        f.memtoreg = $urandom_range(0, 1); f.aluop = $urandom_range(0, 15);
        f.alusrc = $urandom_range(0, 1); f.shamt = $urandom_range(0, 1);
        f.lsop = $urandom_range(0, 7); f.br = $urandom_range(0, 1);
        return f;
    endfunction

    function automatic logic [195:0] pack_bus(input fields_t f);
        return {32'(f.pc), 6'(f.op), 32'(f.rd1), 32'(f.rd2), 32'(f.imm), 32'(f.jmp),
                5'(f.rs), 5'(f.rt), 5'(f.rd),
                1'(f.regdst), 1'(f.regwrite), 1'(f.memread), 1'(f.memwrite), 1'(f.memtoreg),
                4'(f.aluop), 1'(f.alusrc), 1'(f.shamt), 3'(f.lsop), 1'(f.br)};
    endfunction

    // Reference frame built from field values with plain arithmetic.
    function automatic void push_expected(input fields_t f);
        int unsigned w[7];
        w[0] = f.pc; w[1] = f.rd1; w[2] = f.rd2; w[3] = f.imm; w[4] = f.jmp;
        w[5] = f.op * 67108864 + f.rs * 2097152 + f.rt * 65536 + f.rd * 2048;
        w[6] = f.regdst * 16384 + f.regwrite * 8192 + f.memread * 4096 + f.memwrite * 2048
             + f.memtoreg * 1024 + f.aluop * 64 + f.alusrc * 32 + f.shamt * 16
             + f.lsop * 2 + f.br;
        exp_q.push_back(8'hA5);
        for (int k = 0; k < 7; k++) begin
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(8'((w[k] >> (8 * b)) & 32'hFF));
            end
        end
        exp_done++;
    endfunction

    // Ready driver: 0 = always ready, 1 = pattern 1,0,0,1, 2 = random.
    initial begin
        int ph;
        ph = 0;
        i_tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1:       i_tx_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
                2:       i_tx_ready = 1'($urandom_range(0, 1));
                default: i_tx_ready = 1'b1;
            endcase
            ph++;
        end
    end

    // Monitor: scoreboard pops, stall stability, busy/done consistency.
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] want;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (prev_stall) begin
                    chk("stall_valid", 32'(o_tx_valid), 32'd1);
                    chk("stall_data", 32'(o_tx_data), 32'(prev_data));
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_byte got=%0h want=none at %0t", o_tx_data, $time);
                    end else begin
                        want = exp_q.pop_front();
                        chk("frame_byte", 32'(o_tx_data), 32'(want));
                        popped_in_frame++;
                    end
                end
                chk("busy", 32'(o_busy), 32'(o_tx_valid || o_done));
                if (o_done) begin
                    got_done++;
                    chk("done_bytes_left", 32'(exp_q.size()), 32'd0);
                    chk("done_valid", 32'(o_tx_valid), 32'd0);
                end
                prev_stall = o_tx_valid && !i_tx_ready;
                prev_data  = o_tx_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    // Call at posedge+1 with the DUT idle; returns just after the first byte appears.
    task automatic issue(input fields_t f);
        i_id_ex_bus = pack_bus(f);
        i_snap_req  = 1'b1;
        push_expected(f);
        popped_in_frame = 0;
        @(posedge clk);
        #1;
        i_snap_req  = 1'b0;
        i_id_ex_bus = pack_bus(rand_fields());
        @(negedge clk);
        chk("start_valid", 32'(o_tx_valid), 32'd1);
        chk("start_header", 32'(o_tx_data), 32'hA5);
    endtask

    // Wait for o_done (bounded), then return at posedge+1 of the following IDLE cycle.
    task automatic wait_done();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_done && n < 400);
        if (!o_done) begin
            checks++;
            errors++;
            $display("FAIL done_timeout got=0 want=1 at %0t", $time);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        fields_t f;
        int      n;
        rst         = 1'b0;
        i_snap_req  = 1'b1;
        i_id_ex_bus = pack_bus(rand_fields());

        // 1: reset held with a request pending
        repeat (3) begin
            @(negedge clk);
            chk("rst_data", 32'(o_tx_data), 32'd0);
            chk("rst_valid", 32'(o_tx_valid), 32'd0);
            chk("rst_busy", 32'(o_busy), 32'd0);
            chk("rst_done", 32'(o_done), 32'd0);
        end
        @(posedge clk);
        #1;
        rst        = 1'b1;
        i_snap_req = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_valid", 32'(o_tx_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // 2: directed frame, always ready
        f = rand_fields();
        f.pc = 32'h0040_0010; f.rd1 = 32'hDEAD_BEEF; f.op = 6'h23;
        f.rs = 5; f.rt = 9; f.rd = 31;
        f.regdst = 0; f.regwrite = 1; f.memread = 0; f.memwrite = 0; f.memtoreg = 0;
        f.aluop = 4'hA; f.alusrc = 0; f.shamt = 0; f.lsop = 0; f.br = 0;
        issue(f);
        wait_done();

        // 3: back-pressure pattern
        ready_mode = 1;
        issue(rand_fields());
        wait_done();

        // 4: bus churn and a mid-frame request
        ready_mode = 0;
        issue(rand_fields());
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            i_id_ex_bus = pack_bus(rand_fields());
            i_snap_req  = (i == 10);
        end
        i_snap_req = 1'b0;
        wait_done();
        repeat (5) begin
            @(negedge clk);
            chk("no_second_frame", 32'(o_tx_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // 5: reset at byte 12
        issue(rand_fields());
        n = 0;
        while (popped_in_frame < 12 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("reach_byte12", 32'(popped_in_frame >= 12), 32'd1);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_done--;
        @(negedge clk);
        chk("abort_valid", 32'(o_tx_valid), 32'd0);
        chk("abort_busy", 32'(o_busy), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        issue(rand_fields());
        wait_done();

        // 6: back-to-back frames, request in the IDLE cycle after done
        issue(rand_fields());
        wait_done();
        ready_mode = 2;
        for (int k = 0; k < 3; k++) begin
            issue(rand_fields());
            wait_done();
        end
        ready_mode = 0;

        repeat (3) @(posedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        chk("done_count", 32'(got_done), 32'(exp_done));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
